// File: rtl/seven_seg_pkg.sv
// Shared constants for the 4-digit seven-segment scanner: active-low
// segment patterns {g,f,e,d,c,b,a} and the digit-slot indices.
package seven_seg_pkg;

    localparam int NDIG = 4;

    localparam logic [1:0] IDX_ONES = 2'd0;
    localparam logic [1:0] IDX_TENS = 2'd1;
    localparam logic [1:0] IDX_HUND = 2'd2;
    localparam logic [1:0] IDX_SIGN = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ERR   = 7'b0000110;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seven_seg_scanner_seg_decoder.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show 'E'.
module seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_ERR;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit display driver with per-frame input snapshot and
// inter-slot blanking gap. Optional LEADING_ZERO_BLANK_EN blanks leading zeros.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIV = 1000,
    parameter int GAP = 4
) (
    input  logic       CE,
    input  logic       RESET,
    input  logic [3:0] CNT1,
    input  logic [3:0] CNT2,
    input  logic [3:0] CNT3,
    input  logic       REVERSE,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       FRAME
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0] p_q, p_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    cnt1_q, cnt2_q, cnt3_q;
    logic          rev_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_q, frame_d;

    logic          takeSnap;
    logic [3:0]    d1, d2, d3;
    logic          rv;
    logic [3:0]    digit;
    logic [6:0]    decSeg;
    logic          blankDigit;
    logic          inGap;

    // On a snapshot edge the live inputs already drive this cycle's pattern.
    always_comb begin
        takeSnap = (p_q == '0) && (idx_q == IDX_ONES);
        d1 = takeSnap ? CNT1    : cnt1_q;
        d2 = takeSnap ? CNT2    : cnt2_q;
        d3 = takeSnap ? CNT3    : cnt3_q;
        rv = takeSnap ? REVERSE : rev_q;
    end

    always_comb begin
        digit = 4'd0;
        case (idx_q)
            IDX_ONES: digit = d1;
            IDX_TENS: digit = d2;
            IDX_HUND: digit = d3;
            default:  digit = 4'd0;
        endcase
    end

    seg_decoder u_dec (
        .bcd_i (digit),
        .seg_o (decSeg)
    );

    always_comb begin
        blankDigit = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q == IDX_HUND)
            blankDigit = (d3 == 4'd0);
        else if (idx_q == IDX_TENS)
            blankDigit = (d3 == 4'd0) && (d2 == 4'd0);
`endif
    end

    always_comb begin
        p_d     = p_q + PW'(1);
        idx_d   = idx_q;
        an_d    = 4'b1111;
        seg_d   = SEG_BLANK;
        frame_d = takeSnap;
        inGap   = (int'(p_q) < GAP);

        if (p_q == PW'(DIV - 1)) begin
            p_d   = '0;
            idx_d = (int'(idx_q) == NDIG - 1) ? IDX_ONES : idx_q + 2'd1;
        end

        if (!inGap) begin
            an_d[idx_q] = 1'b0;
            if (idx_q == IDX_SIGN)
                seg_d = rv ? SEG_DASH : SEG_BLANK;
            else if (blankDigit)
                seg_d = SEG_BLANK;
            else
                seg_d = decSeg;
        end
    end

    always_ff @(posedge CE or posedge RESET) begin
        if (RESET) begin
            p_q     <= '0;
            idx_q   <= IDX_ONES;
            cnt1_q  <= 4'd0;
            cnt2_q  <= 4'd0;
            cnt3_q  <= 4'd0;
            rev_q   <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
            frame_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
            if (takeSnap) begin
                cnt1_q <= CNT1;
                cnt2_q <= CNT2;
                cnt3_q <= CNT3;
                rev_q  <= REVERSE;
            end
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign FRAME = frame_q;

endmodule
